// File: rtl/fetch_decode_stage.sv
// PC generation, instruction fetch addressing and IF/ID register for the RV32 pipeline.
// A one-entry hold buffer hides the synchronous BRAM read latency across decode stalls.
module fetch_decode_stage #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            PCSrc_E,
  input  logic [XLEN-1:0] PCTarget_E,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] PCF,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic [31:0]     InstrD,
  output logic            ValidD
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(3'd4);

  logic [XLEN-1:0] pcf_q, pcf_d;
  logic [XLEN-1:0] pcd_q, pcd_d;
  logic [XLEN-1:0] pcplus4d_q, pcplus4d_d;
  logic            validd_q, validd_d;
  logic            hold_valid_q, hold_valid_d;
  logic [31:0]     instr_hold_q, instr_hold_d;
  logic [XLEN-1:0] pcf_plus4_s;

  // Next-state logic: redirect beats stall for both the PC and the IF/ID slot
  always_comb begin
    pcf_plus4_s  = pcf_q + PC_STEP;
    pcf_d        = pcf_q;
    pcd_d        = pcd_q;
    pcplus4d_d   = pcplus4d_q;
    validd_d     = validd_q;
    hold_valid_d = hold_valid_q;
    instr_hold_d = instr_hold_q;

    if (PCSrc_E) begin
      pcf_d = {PCTarget_E[XLEN-1:2], 2'b00};
    end else if (StallF) begin
      pcf_d = pcf_q;
    end else begin
      pcf_d = pcf_plus4_s;
    end

    if (PCSrc_E) begin
      validd_d = 1'b0;
    end else if (StallD) begin
      validd_d = validd_q;
    end else begin
      pcd_d      = pcf_q;
      pcplus4d_d = pcf_plus4_s;
      validd_d   = 1'b1;
    end

    // The BRAM re-reads PCF while stalled, so the decode word is captured on the first stalled edge only
    if (PCSrc_E || !StallD) begin
      hold_valid_d = 1'b0;
    end else if (!hold_valid_q) begin
      hold_valid_d = 1'b1;
      instr_hold_d = imem_rdata;
    end else begin
      hold_valid_d = 1'b1;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      pcf_q        <= RESET_PC;
      pcd_q        <= '0;
      pcplus4d_q   <= '0;
      validd_q     <= 1'b0;
      hold_valid_q <= 1'b0;
      instr_hold_q <= NOP_INSTR;
    end else begin
      pcf_q        <= pcf_d;
      pcd_q        <= pcd_d;
      pcplus4d_q   <= pcplus4d_d;
      validd_q     <= validd_d;
      hold_valid_q <= hold_valid_d;
      instr_hold_q <= instr_hold_d;
    end
  end

  // Decode instruction select: bubble, held word, or live BRAM data
  always_comb begin
    InstrD = imem_rdata;
    if (!validd_q) begin
      InstrD = NOP_INSTR;
    end else if (hold_valid_q) begin
      InstrD = instr_hold_q;
    end else begin
      InstrD = imem_rdata;
    end
  end

  assign imem_addr = pcf_q;
  assign PCF       = pcf_q;
  assign PCD       = pcd_q;
  assign PCPlus4D  = pcplus4d_q;
  assign ValidD    = validd_q;

endmodule
